// File: rtl/spi_pkg.sv
// Shared SPI slave types: FSM state encoding and SPI mode bit encodings.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    // CPOL: level of SCLK while the bus is idle
    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;

    // CPHA: which SCLK edge of each bit period samples the data
    localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
    localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input into the clk domain.
// Latency: 2 clk from pin change to q.
// Backpressure: none, free-running.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; reset to the input's idle level so no false edge appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave moving WIDTH-bit words: shifts tx words out on miso, assembles rx words from mosi.
// Latency: 3 clk from pin to internal edge event; rx_valid 1 clk after the final sample edge is seen.
// Backpressure: tx_ready low while the one-word holding register is full; rx side never stalls.
module spi_word_slave
    import spi_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic sclk_s, cs_s, mosi_s;

    sync2 #(.RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

    spi_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             hold_full_q, hold_full_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             sclk_prev_q, sclk_prev_d;
    logic             cs_prev_q, cs_prev_d;
    logic [1:0]       init_q, init_d;
    logic             armed_q, armed_d;

    logic             settled;
    logic             sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic             sample_edge, shift_edge, cs_fall;
    logic             consume;
    logic [WIDTH-1:0] rx_word, tx_shifted, load_word, reload_word;

    // Edges are found by comparing the synchronised level with a third stage.
    // SCLK activity while deselected never reaches the shift logic.
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = (CPOL == CPOL_IDLE_HIGH) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL == CPOL_IDLE_HIGH) ? sclk_rise : sclk_fall;
    assign sample_edge = ~cs_s & ((CPHA == CPHA_SAMPLE_LEAD) ? lead_edge : trail_edge);
    assign shift_edge  = ~cs_s & ((CPHA == CPHA_SAMPLE_LEAD) ? trail_edge : lead_edge);
    assign cs_fall     = ~cs_s & cs_prev_q;

    // The synchronisers carry reset values for a few clocks after reset; chip select
    // must be seen genuinely high once before a falling edge may open a frame, so a
    // master that held cs_n low across reset has to deselect first.
    assign settled = (init_q == 2'd3);

    // Word assembly, tx shift and the word chosen for a load (holding word or echo)
    always_comb begin
        if (MSB_FIRST) begin
            rx_word    = {rx_sh_q[WIDTH-2:0], mosi_s};
            tx_shifted = {tx_sh_q[WIDTH-2:0], 1'b0};
        end else begin
            rx_word    = {mosi_s, rx_sh_q[WIDTH-1:1]};
            tx_shifted = {1'b0, tx_sh_q[WIDTH-1:1]};
        end
        load_word   = hold_full_q ? hold_q : ~rx_data_q;
        reload_word = hold_full_q ? hold_q : ~rx_word;
    end

    // Next-state: FSM, bit counter, shift registers, holding register and pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        consume     = 1'b0;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        init_d      = settled ? init_q : init_q + 2'd1;
        armed_d     = armed_q | (settled & cs_s);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cs_fall && armed_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                rx_sh_d = '0;
                tx_sh_d = load_word;
                consume = hold_full_q;
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        rx_sh_d    = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        tx_sh_d    = reload_word;
                        consume    = hold_full_q;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        rx_sh_d = rx_word;
                    end
                end else if (shift_edge && (cnt_q != '0)) begin
                    // A shift edge before the first sample of a word would skip the
                    // bit just presented (first edge for CPHA=1, the edge right after
                    // a reload for CPHA=0), so only shift once a bit has been sampled.
                    tx_sh_d = tx_shifted;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Deselect ends the frame from any state; a partial word is dropped
        if (cs_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rx_sh_d = '0;
            if ((state_q != ST_IDLE) && (cnt_q != '0)) begin
                frame_err_d = 1'b1;
            end
        end

        // Consumption is applied first so a same-cycle offer is never lost
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            init_q      <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            init_q      <= init_d;
            armed_q     <= armed_d;
        end
    end

    // miso shows the word being loaded during LOAD so the first bit is early
    always_comb begin
        miso = 1'b0;
        case (state_q)
            ST_LOAD:  miso = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
            ST_SHIFT: miso = MSB_FIRST ? tx_sh_q[WIDTH-1] : tx_sh_q[0];
            default:  miso = 1'b0;
        endcase
    end

    assign miso_oe   = (state_q != ST_IDLE);
    assign tx_ready  = ~hold_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
